// File: rtl/multi_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, state
// encodings, ALU/PC select codes and the bundled control-output struct.
`timescale 1ns/1ps
package multi_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for the last state of every real instruction (the ones that
  // count as retired when they hand back to FETCH).
  function automatic logic retires(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RTYPEWB) ||
           (s == S_BEQEX) || (s == S_JEX)   || (s == S_ADDIWB);
  endfunction

endpackage

// File: rtl/multi_ctrl_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
`timescale 1ns/1ps
interface multi_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             ir_write;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, state, retired
  );

  modport slave (
    output opcode,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, state, retired
  );
endinterface

// File: rtl/multi_ctrl_out.sv
// Moore output decode: state -> datapath control strobes/selects.
`timescale 1ns/1ps
module multi_ctrl_out
  import multi_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Everything defaults low; each state raises only its own strobes.
  // Illegal encodings fall through with all outputs low.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
      end
      S_JEX: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS-style main controller: state register, next-state
// logic, decode-time opcode latch and retired-instruction counter.
`timescale 1ns/1ps
module multi_ctrl
  import multi_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  multi_ctrl_if.master  bus
);

  state_t           state_q, state_d;
  logic [5:0]       opc_q, opc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl;

  // State, latched opcode and counter; reset drops everything to FETCH/0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      retired_q <= retired_d;
    end
  end

  // Next state; DECODE branches on the live opcode and also captures it
  // so MEMADR chooses lw/sw from the copy, not the possibly-changed input.
  always_comb begin
    state_d   = S_FETCH;
    opc_d     = opc_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        opc_d = bus.opcode;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opc_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
    if (retires(state_q))
      retired_d = retired_q + CNT_W'(1);
  end

  multi_ctrl_out u_out (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Drive the bundle from the decoded struct.
  always_comb begin
    bus.pc_write      = ctrl.pc_write;
    bus.pc_write_cond = ctrl.pc_write_cond;
    bus.i_or_d        = ctrl.i_or_d;
    bus.mem_read      = ctrl.mem_read;
    bus.mem_write     = ctrl.mem_write;
    bus.mem_to_reg    = ctrl.mem_to_reg;
    bus.ir_write      = ctrl.ir_write;
    bus.reg_write     = ctrl.reg_write;
    bus.reg_dst       = ctrl.reg_dst;
    bus.alu_src_a     = ctrl.alu_src_a;
    bus.alu_src_b     = ctrl.alu_src_b;
    bus.alu_op        = ctrl.alu_op;
    bus.pc_source     = ctrl.pc_source;
    bus.state         = state_q;
    bus.retired       = retired_q;
  end

endmodule

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  6  instruction[31:26] from IR; sampled only in DECODE.
REQ-005 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a  output  1 each  datapath strobes/selects.
REQ-006 alu_src_b  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-007 alu_op  output  2  00 add, 01 sub, 10 funct-decoded.
REQ-008 pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 state  output  4  current state encoding, debug only.
REQ-010 retired  output  CNT_W  count of completed instructions.

Function
REQ-011 Moore FSM; all control outputs SHALL be pure functions of state; outputs not listed for a state SHALL be 0.
REQ-012 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, JEX 9, ADDIEX 10, ADDIWB 11; codes 12-15 SHALL return to FETCH next cycle.
REQ-013 FETCH: mem_read, ir_write, pc_write =1; alu_src_b=01; others 0; next DECODE.
REQ-014 DECODE: alu_src_b=11, alu_op=00; next by opcode: 100011/101011 MEMADR, 000000 RTYPEEX, 000100 BEQEX, 000010 JEX, 001000 ADDIEX, any other FETCH.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10; next MEMRD if latched opcode 100011 else MEMWR.
REQ-016 MEMRD: mem_read=1, i_or_d=1; next MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-017 MEMWR: mem_write=1, i_or_d=1; next FETCH.
REQ-018 RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10; next RTYPEWB. RTYPEWB: reg_write=1, reg_dst=1; next FETCH.
REQ-019 BEQEX: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01; next FETCH.
REQ-020 JEX: pc_write=1, pc_source=10; next FETCH.
REQ-021 ADDIEX: alu_src_a=1, alu_src_b=10; next ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-022 Opcode SHALL be latched into an internal register at DECODE so MEMADR branching ignores later opcode changes.
REQ-023 Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
REQ-024 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, JEX, ADDIWB; unknown opcodes and illegal states SHALL NOT count; counter wraps modulo 2^CNT_W.
REQ-025 reg_write and mem_write SHALL never be asserted in the same cycle.

Reset
REQ-026 rst high SHALL immediately force state=FETCH, retired=0, latched opcode=0, independent of clk.
REQ-027 Outputs during/after reset SHALL equal FETCH decoding (mem_read=ir_write=pc_write=1, alu_src_b=01).
REQ-028 Reset mid-instruction SHALL abandon it without strobes from later states and without incrementing retired.

Structure
REQ-029 Shared package multi_pkg SHALL hold opcode constants, state encodings, alu_op and pc_source codes.
REQ-030 One combinational sub-module multi_ctrl_out (state -> control outputs) is natural; state register, next-state logic, opcode latch and counter remain in multi_ctrl.

Verification
REQ-031 Assert rst at t=0.1ns for 0.2ns -> state=0, retired=0, FETCH outputs present before first clk edge.
REQ-032 opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB; retired 0->1.
REQ-033 opcode=101011 then 000000 back-to-back -> sw path 0,1,2,5 then R path 0,1,6,7; retired=2 after 8 cycles.
REQ-034 opcode=000100, then 000010 -> BEQEX shows pc_write_cond=1, pc_source=01; JEX shows pc_write=1, pc_source=10; 3 cycles each.
REQ-035 opcode=111111 -> 0,1,0; retired unchanged; opcode changed to 101011 during MEMADR of an lw -> still MEMRD.
REQ-036 rst pulsed asynchronously while in MEMRD -> state=0 before next edge, retired unchanged at 0, no reg_write pulse.
